// File: rtl/acpi_pwrbtn_ctrl.sv
// ACPI button front-end: per-channel synchroniser, debouncer and short/long press
// classifier, feeding an S5/S0/S3 sleep-state sequencer with request/ack handshake.
module acpi_pwrbtn_ctrl #(
  parameter int NUM_BTN     = 2,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_BTN-1:0] btn_ni,
  input  logic [CNT_W-1:0]   debounce_cyc_i,
  input  logic [CNT_W-1:0]   long_cyc_i,
  input  logic               pwr_ack_i,
  input  logic               sci_clr_i,
  output logic [NUM_BTN-1:0] btn_state_o,
  output logic [NUM_BTN-1:0] short_evt_o,
  output logic [NUM_BTN-1:0] long_evt_o,
  output logic               pwr_req_o,
  output logic               slp_req_o,
  output logic               force_off_o,
  output logic               sci_irq_o,
  output logic [2:0]         sstate_o
);

  typedef enum logic [2:0] {
    ST_S5       = 3'd0,
    ST_ON_WAIT  = 3'd1,
    ST_S0       = 3'd2,
    ST_SLP_WAIT = 3'd3,
    ST_S3       = 3'd4
  } state_t;

  // A debounce threshold of zero behaves like one cycle.
  logic [CNT_W-1:0] db_last;
  logic             long_en;

  assign db_last = (debounce_cyc_i == '0) ? '0 : debounce_cyc_i - CNT_W'(1);
  assign long_en = |long_cyc_i;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       db_cnt_reg;
    logic [CNT_W-1:0]       hold_cnt_reg;
    logic                   state_reg;
    logic                   state_d_reg;
    logic                   long_flag_reg;
    logic                   short_reg;
    logic                   synced;
    logic                   long_hit;

    assign synced   = ~sync_reg[SYNC_STAGES-1];
    assign long_hit = state_reg & ~long_flag_reg & long_en & (hold_cnt_reg == long_cyc_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_reg      <= '1;
        db_cnt_reg    <= '0;
        hold_cnt_reg  <= '0;
        state_reg     <= 1'b0;
        state_d_reg   <= 1'b0;
        long_flag_reg <= 1'b0;
        short_reg     <= 1'b0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_ni[gi]};

        if (synced == state_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg >= db_last) begin
          state_reg  <= synced;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + CNT_W'(1);
        end

        state_d_reg <= state_reg;
        short_reg   <= state_d_reg & ~state_reg & ~long_flag_reg;

        // The long flag survives the first released cycle so the short decision can see it.
        if (!state_reg) begin
          hold_cnt_reg  <= '0;
          long_flag_reg <= 1'b0;
        end else begin
          if (hold_cnt_reg != '1) begin
            hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
          end
          if (long_hit) begin
            long_flag_reg <= 1'b1;
          end
        end
      end
    end

    assign btn_state_o[gi] = state_reg;
    assign short_evt_o[gi] = short_reg;
    assign long_evt_o[gi]  = long_hit;
  end

  state_t state_reg, state_next;
  logic   from_s3_reg, from_s3_next;
  logic   force_reg, force_next;
  logic   sci_reg, sci_next;
  logic   sci_set;

  always_comb begin
    state_next   = state_reg;
    from_s3_next = from_s3_reg;
    force_next   = 1'b0;
    sci_set      = 1'b0;
    case (state_reg)
      ST_S5: begin
        if (short_evt_o[0]) begin
          state_next   = ST_ON_WAIT;
          from_s3_next = 1'b0;
        end
      end
      ST_ON_WAIT: begin
        if (long_evt_o[0]) begin
          state_next = ST_S5;
          force_next = 1'b1;
        end else if (pwr_ack_i) begin
          state_next = ST_S0;
        end
      end
      ST_S0: begin
        if (long_evt_o[0]) begin
          state_next = ST_S5;
          force_next = 1'b1;
        end else if (short_evt_o[0]) begin
          sci_set = 1'b1;
        end else if (short_evt_o[1]) begin
          state_next = ST_SLP_WAIT;
        end
      end
      ST_SLP_WAIT: begin
        if (long_evt_o[0]) begin
          state_next = ST_S5;
          force_next = 1'b1;
        end else if (pwr_ack_i) begin
          state_next = ST_S3;
        end
      end
      ST_S3: begin
        if (long_evt_o[0]) begin
          state_next = ST_S5;
          force_next = 1'b1;
        end else if (|short_evt_o) begin
          state_next   = ST_ON_WAIT;
          from_s3_next = 1'b1;
        end
      end
      default: state_next = ST_S5;
    endcase

    if (sci_set) begin
      sci_next = 1'b1;
    end else if (force_next || sci_clr_i) begin
      sci_next = 1'b0;
    end else begin
      sci_next = sci_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= ST_S5;
      from_s3_reg <= 1'b0;
      force_reg   <= 1'b0;
      sci_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      from_s3_reg <= from_s3_next;
      force_reg   <= force_next;
      sci_reg     <= sci_next;
    end
  end

  // ON_WAIT reports the state it is waking from; SLP_WAIT is still S0.
  always_comb begin
    sstate_o = 3'd5;
    case (state_reg)
      ST_S5:       sstate_o = 3'd5;
      ST_ON_WAIT:  sstate_o = from_s3_reg ? 3'd3 : 3'd5;
      ST_S0:       sstate_o = 3'd0;
      ST_SLP_WAIT: sstate_o = 3'd0;
      ST_S3:       sstate_o = 3'd3;
      default:     sstate_o = 3'd5;
    endcase
  end

  assign pwr_req_o   = (state_reg == ST_ON_WAIT);
  assign slp_req_o   = (state_reg == ST_SLP_WAIT);
  assign force_off_o = force_reg;
  assign sci_irq_o   = sci_reg;

endmodule

// File: tb/tb_acpi_pwrbtn_ctrl.sv
// Bench for acpi_pwrbtn_ctrl: cycle-level reference model compared every cycle,
// a debounce vector table, directed power-sequencing scenarios and random stimulus.
module tb_acpi_pwrbtn_ctrl;
  localparam int NB   = 3;
  localparam int CW   = 24;
  localparam int SS   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn;
  logic [CW-1:0] deb;
  logic [CW-1:0] long_cyc;
  logic          ack;
  logic          clr;
  logic [NB-1:0] btn_state, short_evt, long_evt;
  logic          pwr_req, slp_req, force_off, sci_irq;
  logic [2:0]    sstate;

  acpi_pwrbtn_ctrl #(.NUM_BTN(NB), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .btn_ni(btn), .debounce_cyc_i(deb), .long_cyc_i(long_cyc),
    .pwr_ack_i(ack), .sci_clr_i(clr), .btn_state_o(btn_state), .short_evt_o(short_evt),
    .long_evt_o(long_evt), .pwr_req_o(pwr_req), .slp_req_o(slp_req), .force_off_o(force_off),
    .sci_irq_o(sci_irq), .sstate_o(sstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. The ACPI state is kept as the reported number plus a pending request
  // (0 none, 1 power-on, 2 sleep) rather than as a state machine encoding.
  logic [NB-1:0] m_pipe [SS];
  logic [NB-1:0] n_pipe [SS];
  int            m_run [NB], n_run [NB];
  int            m_age [NB], n_age [NB];
  logic [NB-1:0] m_db, n_db, m_dbd, n_dbd, m_fired, n_fired, m_short, n_short, exp_long;
  int            m_acpi, n_acpi, m_pend, n_pend;
  logic          m_sci, n_sci, m_force, n_force;

  always_comb begin
    int   thr;
    logic set_sci;
    n_pipe  = m_pipe;
    n_run   = m_run;
    n_age   = m_age;
    n_db    = m_db;
    n_dbd   = m_db;
    n_fired = m_fired;
    n_short = '0;
    n_acpi  = m_acpi;
    n_pend  = m_pend;
    n_force = 1'b0;
    set_sci = 1'b0;
    thr     = (deb == '0) ? 1 : int'(deb);
    for (int i = 0; i < NB; i++) begin
      exp_long[i] = m_db[i] && !m_fired[i] && (long_cyc != '0) && (m_age[i] == int'(long_cyc));
    end
    for (int i = 0; i < NB; i++) begin
      if (m_pipe[SS-1][i] == m_db[i]) begin
        n_run[i] = 0;
      end else begin
        n_run[i] = m_run[i] + 1;
        if (n_run[i] >= thr) begin
          n_db[i]  = m_pipe[SS-1][i];
          n_run[i] = 0;
        end
      end
      n_short[i] = m_dbd[i] && !m_db[i] && !m_fired[i];
      if (n_db[i] && !m_db[i]) begin
        n_fired[i] = 1'b0;
        n_age[i]   = 0;
      end else if (m_db[i]) begin
        if (exp_long[i]) n_fired[i] = 1'b1;
        if (m_age[i] < MAXC) n_age[i] = m_age[i] + 1;
      end
    end
    n_pipe[0] = ~btn;
    for (int s = 1; s < SS; s++) n_pipe[s] = m_pipe[s-1];

    if (exp_long[0] && !(m_acpi == 5 && m_pend == 0)) begin
      n_acpi  = 5;
      n_pend  = 0;
      n_force = 1'b1;
    end else if (m_pend == 1) begin
      if (ack) begin n_acpi = 0; n_pend = 0; end
    end else if (m_pend == 2) begin
      if (ack) begin n_acpi = 3; n_pend = 0; end
    end else if (m_acpi == 5) begin
      if (m_short[0]) n_pend = 1;
    end else if (m_acpi == 0) begin
      if (m_short[0]) set_sci = 1'b1;
      else if (m_short[1]) n_pend = 2;
    end else begin
      if (|m_short) n_pend = 1;
    end
    n_sci = set_sci ? 1'b1 : ((n_force || clr) ? 1'b0 : m_sci);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pipe  <= '{default: '0};
      m_run   <= '{default: 0};
      m_age   <= '{default: 0};
      m_db    <= '0;
      m_dbd   <= '0;
      m_fired <= '0;
      m_short <= '0;
      m_acpi  <= 5;
      m_pend  <= 0;
      m_sci   <= 1'b0;
      m_force <= 1'b0;
    end else begin
      m_pipe  <= n_pipe;
      m_run   <= n_run;
      m_age   <= n_age;
      m_db    <= n_db;
      m_dbd   <= n_dbd;
      m_fired <= n_fired;
      m_short <= n_short;
      m_acpi  <= n_acpi;
      m_pend  <= n_pend;
      m_sci   <= n_sci;
      m_force <= n_force;
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ev_short [NB];
  int ev_long0;
  int ev_force;

  typedef struct {
    int deb;
    int len;
    int exp_lat;
  } db_vec_t;
  db_vec_t vecs [8];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    logic [15:0] got, exp;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    got = {btn_state, short_evt, long_evt, pwr_req, slp_req, force_off, sci_irq, sstate};
    exp = {m_db, m_short, exp_long, m_pend == 1, m_pend == 2, m_force, m_sci, 3'(m_acpi)};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL cycle %0d outputs: got %h, expected %h", cyc, got, exp);
    end
    for (int i = 0; i < NB; i++) if (short_evt[i]) ev_short[i]++;
    if (long_evt[0]) ev_long0++;
    if (force_off) ev_force++;
  endtask

  task automatic clear_ev();
    for (int i = 0; i < NB; i++) ev_short[i] = 0;
    ev_long0 = 0;
    ev_force = 0;
  endtask

  task automatic press(input int ch, input int len, input int after);
    btn[ch] = 1'b0;
    repeat (len) step();
    btn[ch] = 1'b1;
    repeat (after) step();
  endtask

  task automatic ack_pulse();
    repeat (3) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int  lat;
    int  thr;
    bit  found;
    rst_n    = 1'b0;
    btn      = '1;
    deb      = CW'(100);
    long_cyc = CW'(0);
    ack      = 1'b0;
    clr      = 1'b0;
    clear_ev();
    do_reset();
    check("reset_sstate", int'(sstate), 5);
    check("reset_btn_state", int'(btn_state), 0);
    check("reset_pwr_req", int'(pwr_req), 0);
    check("reset_sci", int'(sci_irq), 0);

    // Debounce table: glitches shorter than the threshold vanish; accepted edges take SS+thr cycles.
    vecs[0] = '{deb: 100, len: 50,  exp_lat: 0};
    vecs[1] = '{deb: 100, len: 200, exp_lat: 102};
    vecs[2] = '{deb: 1,   len: 1,   exp_lat: 3};
    vecs[3] = '{deb: 0,   len: 1,   exp_lat: 3};
    vecs[4] = '{deb: 5,   len: 4,   exp_lat: 0};
    vecs[5] = '{deb: 5,   len: 5,   exp_lat: 7};
    vecs[6] = '{deb: 3,   len: 2,   exp_lat: 0};
    vecs[7] = '{deb: 3,   len: 3,   exp_lat: 5};
    for (int v = 0; v < 8; v++) begin
      deb    = CW'(vecs[v].deb);
      thr    = (vecs[v].deb == 0) ? 1 : vecs[v].deb;
      lat    = 0;
      btn[0] = 1'b0;
      for (int k = 1; k <= vecs[v].len + 2 * thr + 10; k++) begin
        step();
        if (lat == 0 && btn_state[0]) lat = k;
        if (k == vecs[v].len) btn[0] = 1'b1;
      end
      check($sformatf("debounce_vec%0d", v), lat, vecs[v].exp_lat);
    end

    // Power-on from S5 with a short press, then ack.
    do_reset();
    deb      = CW'(100);
    long_cyc = CW'(1000);
    clear_ev();
    press(0, 300, 250);
    check("on_short_evt", ev_short[0], 1);
    check("on_no_long", ev_long0, 0);
    check("on_pwr_req", int'(pwr_req), 1);
    check("on_wait_sstate", int'(sstate), 5);
    repeat (20) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    check("on_ack_sstate", int'(sstate), 0);
    check("on_ack_req_drop", int'(pwr_req), 0);

    // Long hold in S0 forces S5 once and suppresses the short on release.
    clear_ev();
    press(0, 5000, 250);
    check("long_count", ev_long0, 1);
    check("long_no_short", ev_short[0], 0);
    check("long_force", ev_force, 1);
    check("long_sstate", int'(sstate), 5);

    // Sleep via SLP, wake via a wake-only channel.
    deb = CW'(4);
    press(0, 20, 20);
    ack_pulse();
    check("s0_again", int'(sstate), 0);
    press(1, 20, 20);
    check("slp_req", int'(slp_req), 1);
    check("slp_wait_sstate", int'(sstate), 0);
    ack_pulse();
    check("s3_sstate", int'(sstate), 3);
    check("slp_req_drop", int'(slp_req), 0);
    press(2, 20, 20);
    check("wake_sstate", int'(sstate), 3);
    check("wake_pwr_req", int'(pwr_req), 1);
    ack_pulse();
    check("wake_ack_sstate", int'(sstate), 0);

    // SCI: set wins over a simultaneous clear; a lone clear drops it.
    press(0, 20, 20);
    check("sci_set", int'(sci_irq), 1);
    btn[0] = 1'b0;
    repeat (20) step();
    btn[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step();
      if (short_evt[0]) found = 1'b1;
    end
    check("sci_short_seen", int'(found), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    check("sci_set_wins", int'(sci_irq), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    check("sci_cleared", int'(sci_irq), 0);

    // long_cyc_i = 0 turns every press into a short one.
    long_cyc = CW'(0);
    clear_ev();
    press(0, 2000, 20);
    check("nolong_long", ev_long0, 0);
    check("nolong_short", ev_short[0], 1);
    check("nolong_sci", int'(sci_irq), 1);

    // Reset during ON_WAIT drops the request without a clock edge.
    do_reset();
    long_cyc = CW'(1000);
    press(0, 20, 20);
    check("pre_rst_pwr_req", int'(pwr_req), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_pwr_req", int'(pwr_req), 0);
    check("async_rst_sstate", int'(sstate), 5);
    step();
    rst_n = 1'b1;
    step();

    // Random stimulus against the model, thresholds changed live.
    deb      = CW'(2);
    long_cyc = CW'(12);
    for (int seg = 0; seg < 1500; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        deb      = CW'($urandom_range(0, 6));
        long_cyc = CW'($urandom_range(0, 40));
      end
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 2) == 0) btn[i] = ~btn[i];
      end
      ack = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 9) == 0);
      repeat ($urandom_range(1, 25)) step();
    end
    ack = 1'b0;
    clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
